// File: rtl/vecfill.sv
// Operand-array generator: writes a[i]=a_init+i*a_step and b[i]=b_init+i*b_step
// through a shared write port while accumulating sum(a[i]*b[i]).
module vecfill #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic [31:0]       n,
    input  logic [DATA_W-1:0] a_init,
    input  logic [DATA_W-1:0] a_step,
    input  logic [DATA_W-1:0] b_init,
    input  logic [DATA_W-1:0] b_step,
    output logic              mem_we_a,
    output logic              mem_we_b,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] return_val
);

    typedef enum logic [1:0] {
        STATE_0,
        STATE_START,
        STATE_CALC,
        STATE_RET
    } state_t;

    localparam logic [31:0] DEPTH_L = 32'(DEPTH);

    state_t            state, state_nx;
    logic [1:0]        counter, counter_nx;
    logic [31:0]       i, n_lat;
    logic [DATA_W-1:0] a_cur, b_cur, prod, acc;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= STATE_0;
            counter <= '0;
        end else begin
            state   <= state_nx;
            counter <= counter_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        counter_nx = '0;
        case (state)
            STATE_0: begin
                if (start) state_nx = STATE_START;
            end
            STATE_START: begin
                if (i >= n_lat) state_nx = STATE_RET;
                else            state_nx = STATE_CALC;
            end
            STATE_CALC: begin
                if (counter == 2'd2) state_nx = STATE_START;
                else                 counter_nx = counter + 2'd1;
            end
            STATE_RET: state_nx = STATE_0;
            default:   state_nx = STATE_0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            i     <= '0;
            n_lat <= '0;
            a_cur <= '0;
            b_cur <= '0;
            prod  <= '0;
            acc   <= '0;
        end else begin
            case (state)
                STATE_0: begin
                    if (start) begin
                        // Clamp so the address never wraps past the memory.
                        n_lat <= (n > DEPTH_L) ? DEPTH_L : n;
                        a_cur <= a_init;
                        b_cur <= b_init;
                        i     <= '0;
                        acc   <= '0;
                    end
                end
                STATE_CALC: begin
                    if (counter == 2'd1) begin
                        prod <= a_cur * b_cur;
                    end else if (counter == 2'd2) begin
                        acc   <= acc + prod;
                        a_cur <= a_cur + a_step;
                        b_cur <= b_cur + b_step;
                        i     <= i + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_we_a   = 1'b0;
        mem_we_b   = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        busy       = (state != STATE_0);
        done       = (state == STATE_RET);
        return_val = acc;
        if (state == STATE_CALC) begin
            if (counter == 2'd0) begin
                mem_we_a  = 1'b1;
                mem_addr  = i[ADDR_W-1:0];
                mem_wdata = a_cur;
            end else if (counter == 2'd1) begin
                mem_we_b  = 1'b1;
                mem_addr  = i[ADDR_W-1:0];
                mem_wdata = b_cur;
            end
        end
    end

endmodule

// File: tb/tb_vecfill.sv
// Randomized self-checking bench for vecfill against an arithmetic model of
// the written arrays, the sum of products and the completion latency.
module tb_vecfill;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        start;
    logic [31:0] n, a_init, a_step, b_init, b_step;
    logic        mem_we_a, mem_we_b, busy, done;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, return_val;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    vecfill #(.DATA_W(32), .ADDR_W(8), .DEPTH(256)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .n(n),
        .a_init(a_init), .a_step(a_step), .b_init(b_init), .b_step(b_step),
        .mem_we_a(mem_we_a), .mem_we_b(mem_we_b), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .return_val(return_val)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Runs one operation and compares it with the model. pulse_at: cycle
    // offset (relative to acceptance T) at which start is pulsed again while busy.
    task automatic run(input logic [31:0] nn, input logic [31:0] ai, input logic [31:0] as_,
                       input logic [31:0] bi, input logic [31:0] bs, input int pulse_at);
        logic [39:0] got_a[$], got_b[$];
        logic [31:0] exp_sum, av, bv;
        int unsigned nl, done_k;
        bit          both;
        nl = (nn > 32'd256) ? 256 : nn;
        exp_sum = '0;
        done_k = 0;
        both = 1'b0;
        n = nn; a_init = ai; a_step = as_; b_init = bi; b_step = bs;
        check("idle_before_start", {63'd0, busy}, 64'd0);
        start = 1'b1;
        for (int k = 1; k <= 1200; k++) begin
            tick();
            start = (k == pulse_at);
            if (k == 1) begin
                n = $urandom; a_init = $urandom; b_init = $urandom;
            end
            if (mem_we_a && mem_we_b) both = 1'b1;
            if (mem_we_a) got_a.push_back({mem_addr, mem_wdata});
            if (mem_we_b) got_b.push_back({mem_addr, mem_wdata});
            if (done) begin
                done_k = k;
                break;
            end
        end
        start = 1'b0;
        check("done_latency", 64'(done_k), 64'(2 + 4 * nl));
        check("a_write_count", 64'(got_a.size()), 64'(nl));
        check("b_write_count", 64'(got_b.size()), 64'(nl));
        check("no_dual_strobe", {63'd0, both}, 64'd0);
        for (int j = 0; j < int'(nl); j++) begin
            av = ai + 32'(j) * as_;
            bv = bi + 32'(j) * bs;
            exp_sum = exp_sum + av * bv;
            if (j < got_a.size()) check("a_write", 64'(got_a[j]), {24'd0, 8'(j), av});
            if (j < got_b.size()) check("b_write", 64'(got_b[j]), {24'd0, 8'(j), bv});
        end
        check("return_val", 64'(return_val), 64'(exp_sum));
        tick();
        check("idle_after_done", {62'd0, busy, done}, 64'd0);
        check("return_hold", 64'(return_val), 64'(exp_sum));
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {mem_we_a, mem_we_b, busy, done, mem_addr, mem_wdata, return_val}, 64'd0);
    endtask

    initial begin
        int unsigned strobes;
        int unsigned k2;
        sys_rst = 1'b1; start = 1'b0;
        n = '0; a_init = '0; a_step = '0; b_init = '0; b_step = '0;
        tick(); tick();
        check_all_zero("reset_state");
        sys_rst = 1'b0;
        tick();

        run(32'd3, 32'd1, 32'd1, 32'd2, 32'd2, -1);
        run(32'd0, 32'd5, 32'd7, 32'd9, 32'd11, -1);
        run(32'd300, 32'd0, 32'd1, 32'd1, 32'd0, -1);
        run(32'd1, 32'h0001_0000, 32'd3, 32'h0001_0000, 32'd3, -1);
        run(32'd1, 32'hFFFF_FFFF, 32'd0, 32'd2, 32'd0, -1);
        run(32'd4, 32'd10, 32'd3, 32'd20, 32'd5, 5);

        // Reset mid-run, then a fresh run from scratch.
        n = 32'd4; a_init = 32'd3; a_step = 32'd1; b_init = 32'd4; b_step = 32'd1;
        start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            start = 1'b0;
        end
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        check_all_zero("mid_run_reset");
        strobes = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (mem_we_a || mem_we_b || busy) strobes++;
        end
        check("quiet_after_reset", 64'(strobes), 64'd0);
        run(32'd4, 32'd3, 32'd1, 32'd4, 32'd1, -1);

        // start and reset together: reset wins.
        sys_rst = 1'b1; start = 1'b1;
        tick();
        sys_rst = 1'b0; start = 1'b0;
        check("rst_beats_start", {63'd0, busy}, 64'd0);
        tick();
        check("rst_beats_start_2", {63'd0, busy}, 64'd0);

        // start held through done: a new run is accepted right after state_ret.
        n = 32'd1; a_init = 32'd2; a_step = 32'd0; b_init = 32'd3; b_step = 32'd0;
        start = 1'b1;
        k2 = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done) begin
                k2 = k;
                break;
            end
        end
        check("held_done_k", 64'(k2), 64'd6);
        tick();
        check("held_state0", {63'd0, busy}, 64'd0);
        tick();
        start = 1'b0;
        check("held_reaccept", {63'd0, busy}, 64'd1);
        k2 = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done) begin
                k2 = k;
                break;
            end
        end
        check("held_second_done", 64'(k2), 64'd5);
        check("held_second_ret", 64'(return_val), 64'd6);
        tick();

        for (int r = 0; r < 12; r++) begin
            run(32'($urandom_range(0, 20)), $urandom, $urandom, $urandom, $urandom,
                (r % 3 == 0) ? int'($urandom_range(2, 8)) : -1);
        end
        run(32'hFFFF_FFFF, $urandom, $urandom, $urandom, $urandom, -1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/vecfill.md
Name: vecfill

Overview:
- HLS-style FSM that generates the two operand arrays consumed by the dot-product datapath.
- For i = 0..n-1 it writes a[i] = a_init + i*a_step and b[i] = b_init + i*b_step into the operand memories through a shared write port.
- While writing, it accumulates sum(a[i]*b[i]) so verification can cross-check the reader's return value.
- Structure mirrors the generated kernels: state_0 / state_start / state_calc / state_ret with a per-state step counter.

Parameters:
DATA_W, 32, data/accumulator width
ADDR_W, 8, memory address width
DEPTH, 256, words per operand memory; n is clamped to DEPTH

Ports:
sys_clk  input  1  clock, rising edge
sys_rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in state_0
n  input  32  element count, latched on accepted start
a_init  input  DATA_W  first a value
a_step  input  DATA_W  a increment
b_init  input  DATA_W  first b value
b_step  input  DATA_W  b increment
mem_we_a  output  1  write strobe, a memory
mem_we_b  output  1  write strobe, b memory
mem_addr  output  ADDR_W  write address (shared)
mem_wdata  output  DATA_W  write data (shared)
busy  output  1  high in every state except state_0
done  output  1  one-cycle pulse in state_ret
return_val  output  DATA_W  accumulated sum of products

Behaviour:
- Interface: one clock, sys_clk. Reset sys_rst is synchronous and active-high.
- Reset, including mid-operation: the next state is state_0 with counter=0. All internal registers clear to 0 (i, n_lat, a_cur, b_cur, prod, acc).
- Output reset values: mem_we_a=0, mem_we_b=0, mem_addr=0, mem_wdata=0, busy=0, done=0, return_val=0.
- Outputs are Moore-decoded from (cur_state, counter) and register values. There is no write strobe outside state_calc.
- state_0:
  - On start=1: latch n_lat = min(n, DEPTH), a_cur=a_init, b_cur=b_init, i=0, acc=0, then go to state_start.
  - Otherwise stay in state_0.
- state_start (1 cycle):
  - If i >= n_lat, go to state_ret.
  - Else go to state_calc with counter=0.
- state_calc (3 cycles, counter 0..2):
  - c0: mem_we_a=1, mem_addr=i[ADDR_W-1:0], mem_wdata=a_cur.
  - c1: mem_we_b=1, mem_addr=i, mem_wdata=b_cur; prod <= low DATA_W bits of a_cur*b_cur.
  - c2: acc <= acc + prod (mod 2^DATA_W); a_cur += a_step; b_cur += b_step (both wrap); i += 1; go to state_start.
- state_ret (1 cycle): done=1, then state_0.
- return_val = acc at all times.
  - Valid when done=1.
  - Holds until the next accepted start clears it.
- Latency: start accepted in cycle T, then state_start at T+1, done at T+2+4*n_lat.
  - Each element takes 4 cycles (start check + 3 calc).
- Boundary cases:
  - n=0: no write strobes; done at T+2; return_val=0.
  - n>DEPTH: exactly DEPTH elements written; last address DEPTH-1; address never wraps.
  - start while busy: ignored; latched values are unaffected.
  - start held high through done: a new run is accepted in the state_0 cycle after state_ret.
  - start and sys_rst both high: reset wins; no run is accepted that cycle.

Test Plan:
- n=3, a_init=1, a_step=1, b_init=2, b_step=2, start pulsed at T -> a writes (0,1),(1,2),(2,3); b writes (0,2),(1,4),(2,6); done at T+14; return_val=28.
- n=0 -> no mem_we_a/mem_we_b; busy high T+1..T+2; done at T+2; return_val=0.
- n=300, a_init=0, a_step=1, b_init=1, b_step=0 -> 256 a-writes and 256 b-writes, last addr 255; done at T+1026; return_val=32640.
- n=1, a_init=b_init=0x00010000 -> prod truncated to 0; return_val=0. Second run with a_init=0xFFFFFFFF, b_init=2 -> return_val=0xFFFFFFFE.
- Run n=4; pulse start again at T+5 -> ignored; exactly 4 element writes; done at T+18.
- sys_rst=1 at T+7 mid-run -> next cycle all outputs 0, busy=0, no further strobes. A fresh start then gives the correct result from scratch.
